inst_mem_loader: RTL

Boot-time writer for the 1024-byte, little-endian, byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake: a 4-byte length header, the program bytes, then a checksum byte. It writes each program byte into the instruction memory's byte array and holds the multi-cycle CPU in reset until a load completes cleanly. It sits between the host byte source (UART receiver or testbench) and the write port added to the instruction memory, replacing `$readmemh` preloading for hardware bring-up.

---
 rtl/inst_mem_loader_pkg.sv | 29 ++
 rtl/inst_mem_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and types for the boot-time instruction memory loader.
// The memory geometry defaults are also used by the instruction memory itself.
package inst_mem_loader_pkg;

  localparam int MEM_BYTES_DEF = 1024;
  localparam int ADDR_W_DEF    = 10;
  localparam int LEN_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_LENGTH = 2'd1,
    ERR_CSUM   = 2'd2
  } err_code_t;

  // Checksum is a plain byte sum that wraps modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader: 4-byte little-endian length, payload, checksum.
// Writes the payload into instruction memory and holds the CPU until a clean load.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t      state_q, state_d;
  err_code_t   err_code_q, err_code_d;
  logic [31:0] len_q;
  logic [ADDR_W:0] cnt_q;
  logic [7:0]  sum_q;

  logic        accept;
  logic [31:0] hdr_len;
  logic        hdr_last;
  logic        data_last;

  assign busy     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign in_ready = busy;
  assign accept   = in_valid && in_ready;
  assign cpu_hold = (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign err_code = err_code_q;

  // Length arrives LSB first, so the 4th byte completes the word from the top.
  assign hdr_len   = {in_data, len_q[31:8]};
  assign hdr_last  = (cnt_q == (ADDR_W+1)'(LEN_BYTES - 1));
  // Length is already bounded by MEM_BYTES here, so the low ADDR_W+1 bits hold it.
  assign data_last = ((cnt_q + (ADDR_W+1)'(1)) == len_q[ADDR_W:0]);

  // NOTE: every variable gets its default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          err_code_d = ERR_NONE;
        end
      end
      ST_LEN: begin
        if (accept && hdr_last) begin
          if (hdr_len > 32'(MEM_BYTES)) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LENGTH;
          end else if (hdr_len == 32'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept && data_last) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // NOTE: the write-port registers are reset too, because they are outputs
  // whose values are visible to the memory during and after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            len_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len_q <= hdr_len;
            cnt_q <= hdr_last ? '0 : cnt_q + (ADDR_W+1)'(1);
          end
        end
        ST_DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_q[ADDR_W-1:0];
            mem_wdata <= in_data;
            sum_q     <= sum8(sum_q, in_data);
            cnt_q     <= cnt_q + (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
